// File: rtl/hall_call_queue.sv
// ---------------------------------------------------------------------------
// hall_call_queue
//
// Purpose:
//   Collects hall-button presses into one slot per (floor, direction) and
//   offers them one at a time to the main elevator controller through a
//   valid/ready handshake. A round-robin pointer makes sure that every waiting
//   call is eventually offered. A call stays alive (lamp lit) until a car
//   reports that it has served that floor in that direction.
//
//   Slot index s = 2*floor + dir (dir 0 = UP, 1 = DOWN), so there are
//   2*FLOORS slots. The top floor has no up button and floor 0 has no down
//   button, so those two slots never leave IDLE.
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   press_up      per-floor hall up-button press (bit i = floor i)
//   press_down    per-floor hall down-button press
//   served_valid  a car has opened its door at served_floor
//   served_floor  floor being served
//   served_dir    direction served, 0=UP, 1=DOWN
//   req_valid     a hall call is being offered to the main controller
//   req_ready     main controller accepts the offered call
//   req_floor     floor of the offered call
//   req_dir       direction of the offered call
//   lamp_up       up-call lamp per floor
//   lamp_down     down-call lamp per floor
//   outstanding   number of slots that are not IDLE
// ---------------------------------------------------------------------------
module hall_call_queue #(
  parameter int FLOORS = 5,
  parameter int FBITS  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] press_up,
  input  logic [FLOORS-1:0] press_down,
  input  logic              served_valid,
  input  logic [FBITS-1:0]  served_floor,
  input  logic              served_dir,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [FBITS-1:0]  req_floor,
  output logic              req_dir,
  output logic [FLOORS-1:0] lamp_up,
  output logic [FLOORS-1:0] lamp_down,
  output logic [FBITS+1:0]  outstanding
);

  localparam int NSLOTS = 2 * FLOORS;
  localparam int PBITS  = $clog2(NSLOTS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    OFFERED  = 2'd2,
    ASSIGNED = 2'd3
  } slotState_e;

  slotState_e        r_slotState [NSLOTS];
  slotState_e        w_slotNext  [NSLOTS];

  logic [PBITS-1:0]  r_ptr;
  logic [PBITS-1:0]  w_ptrNext;
  logic              r_reqValid;
  logic              w_reqValidNext;
  logic [FBITS-1:0]  r_reqFloor;
  logic [FBITS-1:0]  w_reqFloorNext;
  logic              r_reqDir;
  logic              w_reqDirNext;
  logic [FLOORS-1:0] r_lampUp;
  logic [FLOORS-1:0] r_lampDown;
  logic [FLOORS-1:0] w_lampUpNext;
  logic [FLOORS-1:0] w_lampDownNext;
  logic [FBITS+1:0]  r_outstanding;
  logic [FBITS+1:0]  w_outstandingNext;

  logic [NSLOTS-1:0] w_pressSlot;
  logic              w_servedOk;
  logic [FBITS:0]    w_servedIdx;
  logic [FBITS:0]    w_offerIdx;
  logic              w_servedHitsOffer;
  logic              w_handshake;
  logic              w_reofferAllowed;
  logic [PBITS-1:0]  w_searchBase;
  logic              w_found;
  logic [PBITS-1:0]  w_pickIdx;

  // Map the two button vectors onto slot indices. The two buttons that do
  // not physically exist (up at the top floor, down at floor 0) are masked
  // so their slots can never be requested.
  always_comb begin
    w_pressSlot = '0;
    for (int f = 0; f < FLOORS; f++) begin
      w_pressSlot[2*f]   = press_up[f]   && (f != FLOORS - 1);
      w_pressSlot[2*f+1] = press_down[f] && (f != 0);
    end
  end

  // A served report only counts when its floor exists. The offered slot is
  // identified directly from the offer register, which always holds
  // {floor, dir} of the single OFFERED slot while req_valid is high.
  assign w_servedOk        = served_valid && ({1'b0, served_floor} < (FBITS+1)'(FLOORS));
  assign w_servedIdx       = {served_floor, served_dir};
  assign w_offerIdx        = {r_reqFloor, r_reqDir};
  assign w_servedHitsOffer = w_servedOk && r_reqValid && (w_servedIdx == w_offerIdx);
  assign w_handshake       = r_reqValid && req_ready && !w_servedHitsOffer;
  assign w_reofferAllowed  = !r_reqValid || w_handshake || w_servedHitsOffer;

  // Round-robin search for the next call to offer. After a handshake the
  // search starts just past the slot that was accepted so the next offer can
  // go out on the same edge; otherwise it starts at the stored pointer.
  // Only slots that were already PENDING before this edge qualify, which
  // gives a press one cycle in the lamp before it can be offered, and a slot
  // being served this cycle is skipped because it is about to go IDLE.
  always_comb begin : pickNext
    int base;
    int idx;
    if (w_handshake) begin
      base = int'(w_offerIdx) + 1;
      if (base >= NSLOTS) base = 0;
    end else begin
      base = int'(r_ptr);
    end
    w_searchBase = PBITS'(base);
    w_found      = 1'b0;
    w_pickIdx    = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      idx = base + i;
      if (idx >= NSLOTS) idx = idx - NSLOTS;
      if (!w_found && (r_slotState[idx] == PENDING) &&
          !(w_servedOk && (w_servedIdx == (FBITS+1)'(idx)))) begin
        w_found   = 1'b1;
        w_pickIdx = PBITS'(idx);
      end
    end
  end

  // Per-slot next state. A served report beats a press on the same edge,
  // and beats a handshake on the offered slot too. The slot picked for the
  // next offer is promoted to OFFERED last so it overrides its PENDING
  // value.
  always_comb begin : slotNextState
    logic hit;
    for (int s = 0; s < NSLOTS; s++) begin
      w_slotNext[s] = r_slotState[s];
      hit = w_servedOk && (w_servedIdx == (FBITS+1)'(s));
      case (r_slotState[s])
        IDLE:     if (w_pressSlot[s] && !hit) w_slotNext[s] = PENDING;
        PENDING:  if (hit) w_slotNext[s] = IDLE;
        OFFERED: begin
          if (hit)              w_slotNext[s] = IDLE;
          else if (w_handshake) w_slotNext[s] = ASSIGNED;
        end
        ASSIGNED: if (hit) w_slotNext[s] = IDLE;
        default:  w_slotNext[s] = IDLE;
      endcase
      if (w_reofferAllowed && w_found && (w_pickIdx == PBITS'(s))) begin
        w_slotNext[s] = OFFERED;
      end
    end
  end

  // Offer register and pointer. The offer only changes when the current one
  // has been accepted, withdrawn by a served report, or there is none, so
  // req_floor/req_dir stay stable while the controller stalls.
  always_comb begin
    w_reqValidNext = r_reqValid;
    w_reqFloorNext = r_reqFloor;
    w_reqDirNext   = r_reqDir;
    w_ptrNext      = w_handshake ? w_searchBase : r_ptr;
    if (w_reofferAllowed) begin
      if (w_found) begin
        w_reqValidNext = 1'b1;
        w_reqFloorNext = FBITS'(w_pickIdx >> 1);
        w_reqDirNext   = w_pickIdx[0];
      end else begin
        w_reqValidNext = 1'b0;
      end
    end
  end

  // Lamps and the outstanding count are registered views of the next slot
  // states, so they change on the same edge as the slots themselves.
  always_comb begin
    w_lampUpNext      = '0;
    w_lampDownNext    = '0;
    w_outstandingNext = '0;
    for (int f = 0; f < FLOORS; f++) begin
      w_lampUpNext[f]   = (w_slotNext[2*f]   != IDLE);
      w_lampDownNext[f] = (w_slotNext[2*f+1] != IDLE);
    end
    for (int s = 0; s < NSLOTS; s++) begin
      if (w_slotNext[s] != IDLE) w_outstandingNext = w_outstandingNext + (FBITS+2)'(1);
    end
  end

  // State register. Reset is asynchronous so every output drops the moment
  // rst_n falls, and any in-flight offer is discarded with the slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSLOTS; s++) r_slotState[s] <= IDLE;
      r_ptr         <= '0;
      r_reqValid    <= 1'b0;
      r_reqFloor    <= '0;
      r_reqDir      <= 1'b0;
      r_lampUp      <= '0;
      r_lampDown    <= '0;
      r_outstanding <= '0;
    end else begin
      for (int s = 0; s < NSLOTS; s++) r_slotState[s] <= w_slotNext[s];
      r_ptr         <= w_ptrNext;
      r_reqValid    <= w_reqValidNext;
      r_reqFloor    <= w_reqFloorNext;
      r_reqDir      <= w_reqDirNext;
      r_lampUp      <= w_lampUpNext;
      r_lampDown    <= w_lampDownNext;
      r_outstanding <= w_outstandingNext;
    end
  end

  assign req_valid   = r_reqValid;
  assign req_floor   = r_reqFloor;
  assign req_dir     = r_reqDir;
  assign lamp_up     = r_lampUp;
  assign lamp_down   = r_lampDown;
  assign outstanding = r_outstanding;

endmodule

// File: tb/tb_hall_call_queue.sv
// ---------------------------------------------------------------------------
// tb_hall_call_queue
//
// Purpose:
//   Directed self-checking bench for hall_call_queue (FLOORS=5, FBITS=3).
//   Expected offers ({floor, dir}) are queued when the presses are driven and
//   compared against the offer port when the queue presents it. Inputs are
//   driven and outputs sampled on the falling clock edge.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_hall_call_queue;

  localparam int FLOORS = 5;
  localparam int FBITS  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [FLOORS-1:0] press_up;
  logic [FLOORS-1:0] press_down;
  logic              served_valid;
  logic [FBITS-1:0]  served_floor;
  logic              served_dir;
  logic              req_valid;
  logic              req_ready;
  logic [FBITS-1:0]  req_floor;
  logic              req_dir;
  logic [FLOORS-1:0] lamp_up;
  logic [FLOORS-1:0] lamp_down;
  logic [FBITS+1:0]  outstanding;

  int checkCount = 0;
  int failCount  = 0;
  logic [FBITS:0] expQ [$];

  hall_call_queue #(.FLOORS(FLOORS), .FBITS(FBITS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .press_up     (press_up),
    .press_down   (press_down),
    .served_valid (served_valid),
    .served_floor (served_floor),
    .served_dir   (served_dir),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_floor    (req_floor),
    .req_dir      (req_dir),
    .lamp_up      (lamp_up),
    .lamp_down    (lamp_down),
    .outstanding  (outstanding)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Drive every DUT input in one go.
  task automatic applyStimulus(input logic [FLOORS-1:0] up, input logic [FLOORS-1:0] dn,
                               input logic sv, input logic [FBITS-1:0] sf, input logic sd,
                               input logic rdy);
    press_up     = up;
    press_down   = dn;
    served_valid = sv;
    served_floor = sf;
    served_dir   = sd;
    req_ready    = rdy;
  endtask

  // Advance through one rising edge and stop on the following falling edge.
  task automatic stepClock();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Compare the presented offer with the head of the scoreboard; pop it when
  // the offer is being consumed (accepted or withdrawn).
  task automatic checkOffer(input string tag, input bit popIt);
    logic [FBITS:0] exp;
    if (expQ.size() == 0) begin
      checkCount++;
      failCount++;
      $error("[TB] FAIL %s: observed=offer expected=empty scoreboard", tag);
      return;
    end
    exp = expQ[0];
    checkOutput({tag, "_valid"}, 32'(req_valid), 32'd1);
    checkOutput({tag, "_call"}, 32'({req_floor, req_dir}), 32'(exp));
    if (popIt) void'(expQ.pop_front());
  endtask

  initial begin
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(req_valid), 32'd0);
    checkOutput("rst_floor", 32'(req_floor), 32'd0);
    checkOutput("rst_lamps", 32'({lamp_up, lamp_down}), 32'd0);
    checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single up call at floor 2, accepted immediately, then served.
    applyStimulus(5'b00100, '0, 1'b0, '0, 1'b0, 1'b1);
    expQ.push_back({3'd2, 1'b0});
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("A_lamp", 32'(lamp_up), 32'b00100);
    checkOutput("A_notyet", 32'(req_valid), 32'd0);
    checkOutput("A_out1", 32'(outstanding), 32'd1);
    stepClock();
    checkOffer("A_offer", 1'b1);
    stepClock();
    checkOutput("A_assigned_valid", 32'(req_valid), 32'd0);
    checkOutput("A_assigned_lamp", 32'(lamp_up), 32'b00100);
    stepClock();
    checkOutput("A_assigned_out", 32'(outstanding), 32'd1);
    applyStimulus('0, '0, 1'b1, 3'd2, 1'b0, 1'b1);
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("A_served_lamp", 32'(lamp_up), 32'd0);
    checkOutput("A_served_out", 32'(outstanding), 32'd0);

    // Nonexistent buttons do nothing.
    applyStimulus(5'b10000, 5'b00001, 1'b0, '0, 1'b0, 1'b1);
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("B_lamps", 32'({lamp_up, lamp_down}), 32'd0);
    checkOutput("B_out", 32'(outstanding), 32'd0);
    stepClock();
    checkOutput("B_valid", 32'(req_valid), 32'd0);

    // Reset so the round-robin pointer starts from slot 0 again.
    rst_n = 1'b0;
    stepClock();
    rst_n = 1'b1;

    // Three simultaneous calls: slots 0, 2, 7 offered back to back.
    applyStimulus(5'b00011, 5'b01000, 1'b0, '0, 1'b0, 1'b1);
    expQ.push_back({3'd0, 1'b0});
    expQ.push_back({3'd1, 1'b0});
    expQ.push_back({3'd3, 1'b1});
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("C_lamps", 32'({lamp_up, lamp_down}), 32'({5'b00011, 5'b01000}));
    checkOutput("C_out3", 32'(outstanding), 32'd3);
    checkOutput("C_notyet", 32'(req_valid), 32'd0);
    stepClock();
    checkOffer("C_first", 1'b1);
    stepClock();
    checkOffer("C_second", 1'b1);
    stepClock();
    checkOffer("C_third", 1'b1);
    stepClock();
    checkOutput("C_drained", 32'(req_valid), 32'd0);
    checkOutput("C_assigned_out", 32'(outstanding), 32'd3);
    applyStimulus('0, '0, 1'b1, 3'd0, 1'b0, 1'b1);
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("C_served0_out", 32'(outstanding), 32'd2);
    checkOutput("C_served0_lamp", 32'(lamp_up), 32'b00010);
    applyStimulus(5'b00001, '0, 1'b0, '0, 1'b0, 1'b1);
    expQ.push_back({3'd0, 1'b0});
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("C_repress_wait", 32'(req_valid), 32'd0);
    stepClock();
    checkOffer("C_wrap", 1'b1);
    stepClock();
    checkOutput("C_wrap_done", 32'(req_valid), 32'd0);
    checkOutput("C_wrap_out", 32'(outstanding), 32'd3);

    // Leave an offer in flight, then pulse reset mid-cycle.
    applyStimulus('0, 5'b10000, 1'b0, '0, 1'b0, 1'b0);
    expQ.push_back({3'd4, 1'b1});
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0);
    stepClock();
    checkOffer("R_inflight", 1'b0);
    checkOutput("R_out4", 32'(outstanding), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("R_async_valid", 32'(req_valid), 32'd0);
    checkOutput("R_async_call", 32'({req_floor, req_dir}), 32'd0);
    checkOutput("R_async_lamps", 32'({lamp_up, lamp_down}), 32'd0);
    checkOutput("R_async_out", 32'(outstanding), 32'd0);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    stepClock();
    stepClock();
    checkOutput("R_noreoffer", 32'(req_valid), 32'd0);
    checkOutput("R_out0", 32'(outstanding), 32'd0);

    // Stalled offer held stable, then withdrawn by a served report.
    applyStimulus('0, 5'b01000, 1'b0, '0, 1'b0, 1'b0);
    expQ.push_back({3'd3, 1'b1});
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("D_lamp", 32'(lamp_down), 32'b01000);
    for (int i = 0; i < 4; i++) begin
      stepClock();
      checkOffer("D_hold", 1'b0);
    end
    applyStimulus('0, '0, 1'b1, 3'd3, 1'b1, 1'b1);
    void'(expQ.pop_front());
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("D_withdrawn", 32'(req_valid), 32'd0);
    checkOutput("D_lamp_off", 32'(lamp_down), 32'd0);
    checkOutput("D_out", 32'(outstanding), 32'd0);
    stepClock();
    checkOutput("D_stays_idle", 32'(req_valid), 32'd0);

    // Press and serve of the same slot on one edge: served wins.
    applyStimulus('0, 5'b00010, 1'b1, 3'd1, 1'b1, 1'b1);
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("E_lamp", 32'(lamp_down), 32'd0);
    checkOutput("E_out", 32'(outstanding), 32'd0);
    stepClock();
    checkOutput("E_valid", 32'(req_valid), 32'd0);

    // Served report for a nonexistent floor is ignored.
    applyStimulus(5'b00010, '0, 1'b0, '0, 1'b0, 1'b0);
    expQ.push_back({3'd1, 1'b0});
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b0);
    stepClock();
    checkOffer("F_offer", 1'b0);
    applyStimulus('0, '0, 1'b1, 3'd5, 1'b0, 1'b0);
    stepClock();
    applyStimulus('0, '0, 1'b0, '0, 1'b0, 1'b1);
    checkOffer("F_ignored", 1'b1);
    checkOutput("F_lamp", 32'(lamp_up), 32'b00010);
    stepClock();
    checkOutput("F_accepted", 32'(req_valid), 32'd0);
    checkOutput("F_out", 32'(outstanding), 32'd1);

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
